// File: rtl/azimuth_signal_generator.sv
// Azimuth serial pattern player: on each azimuth trigger it latches DATA and
// shifts one bit out per CLK_PE strobe, starting at bit 0 and wrapping at SIZE.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | output held low, waiting for EN=1 with a TRIG pulse
//   RUN   | playing the latched pattern, one bit per CLK_PE strobe
module azimuth_signal_generator #(
  parameter int SIZE = 3200
) (
  input  logic            SYS_CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            TRIG,
  input  logic            CLK_PE,
  input  logic [SIZE-1:0] DATA,
  output logic            GEN_SIGNAL
);

  // Guard keeps the counter at least one bit wide for a degenerate SIZE=1.
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   pattern_q, pattern_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic              gen_q, gen_d;

  assign idx_inc = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      idx_q     <= '0;
      gen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      idx_q     <= idx_d;
      gen_q     <= gen_d;
    end
  end

  // Priority: disable, then trigger (restart beats a coincident strobe), then strobe.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    idx_d     = idx_q;
    gen_d     = gen_q;
    if (!EN) begin
      state_d = IDLE;
      gen_d   = 1'b0;
    end else if (TRIG) begin
      state_d   = RUN;
      pattern_d = DATA;
      idx_d     = '0;
      gen_d     = DATA[0];
    end else begin
      case (state_q)
        RUN: begin
          if (CLK_PE) begin
            idx_d = idx_inc;
            gen_d = pattern_q[idx_inc];
          end
        end
        default: gen_d = 1'b0;
      endcase
    end
  end

  assign GEN_SIGNAL = gen_q;

endmodule

// File: tb/tb_azimuth_signal_generator.sv
// Bench for azimuth_signal_generator: directed scenarios plus random traffic,
// checked every cycle against a ticks-since-trigger reference model.
module tb_azimuth_signal_generator;

  localparam int SIZE   = 200;
  localparam int PE_PER = 10;
  localparam int Q      = SIZE / 4;

  logic            sys_clk = 1'b0;
  logic            rst;
  logic            en;
  logic            trig;
  logic            clk_pe;
  logic [SIZE-1:0] data;
  logic            gen_signal;

  int total = 0;
  int bad   = 0;

  // Reference model: output is pattern[(strobes since last trigger) mod SIZE].
  logic [SIZE-1:0] m_pat;
  bit              m_run;
  int              m_k;
  logic            m_gen;

  always #5 sys_clk = ~sys_clk;

  azimuth_signal_generator #(.SIZE(SIZE)) dut (
    .SYS_CLK    (sys_clk),
    .RST        (rst),
    .EN         (en),
    .TRIG       (trig),
    .CLK_PE     (clk_pe),
    .DATA       (data),
    .GEN_SIGNAL (gen_signal)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_k   = 0;
    m_pat = '0;
    m_gen = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (!en) begin
      m_run = 1'b0;
      m_gen = 1'b0;
    end else if (trig) begin
      m_run = 1'b1;
      m_pat = data;
      m_k   = 0;
      m_gen = data[0];
    end else if (m_run && clk_pe) begin
      m_k   = m_k + 1;
      m_gen = m_pat[m_k % SIZE];
    end else if (!m_run) begin
      m_gen = 1'b0;
    end
  endtask

  task automatic cyc(input logic e, input logic t, input logic p, input string tag);
    en     = e;
    trig   = t;
    clk_pe = p;
    @(posedge sys_clk);
    model_edge();
    #1;
    chk(tag, gen_signal, m_gen);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      repeat (PE_PER - 1) cyc(1'b1, 1'b0, 1'b0, tag);
      cyc(1'b1, 1'b0, 1'b1, tag);
    end
  endtask

  task automatic quarter_data();
    for (int b = 0; b < SIZE; b++) data[b] = ((b / Q) % 2 == 0);
  endtask

  task automatic rand_data();
    for (int b = 0; b < SIZE; b++) data[b] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    trig   = 1'b0;
    clk_pe = 1'b0;
    quarter_data();
    model_reset();

    #2;
    chk("reset_gen", gen_signal, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    rst = 1'b0;

    // Enabled but never triggered: output must stay low.
    ticks(20, "no_trig_idle");
    chk("no_trig_low", gen_signal, 1'b0);

    // Trigger and play through the quarter-block pattern, including the wrap.
    cyc(1'b1, 1'b1, 1'b0, "trig_start");
    chk("trig_first_high", gen_signal, 1'b1);
    ticks(Q - 1, "block0");
    chk("last_of_block0_high", gen_signal, 1'b1);
    ticks(1, "block1_start");
    chk("block1_low", gen_signal, 1'b0);
    ticks(Q, "block1");
    chk("block2_high", gen_signal, 1'b1);
    ticks(2 * Q, "to_wrap");
    chk("wrap_bit0_high", gen_signal, 1'b1);

    // New DATA must be ignored until a trigger; then a trigger coincident
    // with a strobe restarts at bit 0 of the new data.
    rand_data();
    data[Q + 6] = 1'b1;
    ticks(Q + 6, "data_change_ignored");
    chk("old_pattern_low", gen_signal, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, "trig_pe_same_cycle");
    chk("trig_pe_bit0", gen_signal, data[0]);
    ticks(60, "after_resync");

    // Enable dropped mid-pattern; triggers while disabled are ignored.
    quarter_data();
    cyc(1'b1, 1'b1, 1'b0, "retrig_quarter");
    ticks(10, "pre_en_drop");
    cyc(1'b0, 1'b0, 1'b1, "en_drop");
    chk("en_drop_low", gen_signal, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, "trig_while_disabled");
    cyc(1'b0, 1'b0, 1'b1, "pe_while_disabled");
    ticks(10, "en_back_no_trig");
    chk("en_back_low", gen_signal, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, "retrig_after_en");
    chk("retrig_high", gen_signal, 1'b1);

    // Asynchronous reset mid-pattern, then wait for a fresh trigger.
    ticks(25, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_low", gen_signal, 1'b0);
    model_reset();
    cyc(1'b1, 1'b1, 1'b1, "in_reset");
    rst = 1'b0;
    ticks(10, "post_reset_no_trig");
    chk("post_reset_low", gen_signal, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, "trig_after_reset");
    ticks(5, "after_reset_run");

    // Random traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) rand_data();
      cyc(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 99) == 0),
          1'($urandom_range(0, 3) == 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/azimuth_signal_generator.md
AZIMUTH_SIGNAL_GENERATOR -- requirements
Module: azimuth_signal_generator

Interface
REQ-001 SHALL have parameter SIZE, default 3200, giving the pattern length in bits (one bit per CLK_PE tick).
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port SYS_CLK, input, 1 bit: system clock (100 MHz in system); all state on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port EN, input, 1 bit: enable; low forces idle.
REQ-006 SHALL have port TRIG, input, 1 bit: single-SYS_CLK-cycle start/resync pulse (azimuth reference), already edge-detected upstream.
REQ-007 SHALL have port CLK_PE, input, 1 bit: single-cycle bit-advance strobe (1 us tick, i.e. every 100 SYS_CLK cycles), already edge-detected upstream.
REQ-008 SHALL have port DATA, input, SIZE bits: pattern to play, bit 0 first.
REQ-009 SHALL have port GEN_SIGNAL, output, 1 bit: generated serial signal, registered.

Function
REQ-010 SHALL implement two states, IDLE and RUN; IDLE drives GEN_SIGNAL=0.
REQ-011 In IDLE with EN=1 and TRIG=1, SHALL latch DATA into an internal SIZE-bit pattern register, clear bit index to 0, set GEN_SIGNAL<=DATA[0] at that edge and enter RUN.
REQ-012 In RUN with CLK_PE=1, SHALL advance the index by 1 and drive GEN_SIGNAL<=pattern[index+1] at the same edge (1 SYS_CLK latency from strobe).
REQ-013 Without CLK_PE or TRIG, SHALL hold GEN_SIGNAL and the index unchanged.
REQ-014 SHALL wrap: after bit SIZE-1, the next CLK_PE outputs pattern[0] (index 0) and playback continues.
REQ-015 TRIG in RUN SHALL restart exactly as in REQ-011 (relatch DATA, index 0, output DATA[0]).
REQ-016 TRIG and CLK_PE in the same cycle: TRIG SHALL win and CLK_PE is ignored.
REQ-017 DATA changes SHALL NOT affect output until the next accepted TRIG.
REQ-018 EN=0 SHALL, at the next edge, force GEN_SIGNAL=0 and return to IDLE regardless of TRIG/CLK_PE; re-enabling requires a new TRIG.
REQ-019 The index counter SHALL be $clog2(SIZE) bits wide and compare against SIZE-1 for the wrap; SIZE need not be a power of 2.

Reset
REQ-020 RST=1 SHALL asynchronously force state IDLE, index 0, pattern register 0 and GEN_SIGNAL 0.
REQ-021 Reset released mid-pattern SHALL NOT resume; the block waits for TRIG.

Structure
REQ-022 SHALL need no shared package; SIZE is the only constant and stays a module parameter.
REQ-023 SHALL be a single module with no sub-modules; clock division and edge detection (clk_divider, edge_detect) stay outside it in the enclosing design.
REQ-024 The pattern store SHALL be either a rotate-right shift register (output bit 0) or a latched register with an index mux; either is acceptable if REQ-011..REQ-019 hold.

Verification (SIZE=3200, SYS_CLK 10 ns, CLK_PE every 100 cycles, DATA = bits[799:0]=1, [1599:800]=0, [2399:1600]=1, [3199:2400]=0)
REQ-025 No TRIG, EN=1 for 2 ms -> GEN_SIGNAL stays 0.
REQ-026 TRIG at 1 us -> GEN_SIGNAL=1 one cycle later, stays 1 for 800 CLK_PE ticks, then 0 for 800 ticks, then 1 again.
REQ-027 EN dropped at 1.5 ms mid-pattern -> GEN_SIGNAL=0 next cycle, stays 0 after EN returns until a new TRIG.
REQ-028 Run 3200+ ticks -> tick 3200 outputs bit 0 (1) again, confirming wrap.
REQ-029 TRIG coincident with CLK_PE at tick 900 (output 0) -> output returns to 1 (bit 0) and the index is 0.
REQ-030 RST pulsed at tick 400 -> GEN_SIGNAL=0 immediately (asynchronously), stays 0 until the next TRIG.
